// File: rtl/centroid_tracker_if.sv
// Centroid tracker bus: upstream IPU centroid/frame strobes plus CPU-side
// tracked-coordinate req/ack handshake. The slave side is the tracker.
interface centroid_tracker_if #(
   parameter int unsigned COORD_W = 11
);
   logic               iDVAL;
   logic [COORD_W-1:0] iRow;
   logic [COORD_W-1:0] iCol;
   logic               iFrameEnd;
   logic               iAck;
   logic [COORD_W-1:0] oRow;
   logic [COORD_W-1:0] oCol;
   logic               oValid;
   logic               oReq;
   logic               oOverrun;
   logic [1:0]         oState;

   modport master (
      output iDVAL, iRow, iCol, iFrameEnd, iAck,
      input  oRow, oCol, oValid, oReq, oOverrun, oState
   );

   modport slave (
      input  iDVAL, iRow, iCol, iFrameEnd, iAck,
      output oRow, oCol, oValid, oReq, oOverrun, oState
   );
endinterface

// File: rtl/centroid_tracker.sv
// Per-frame centroid tracker: EMA jitter filter, outlier gate with re-seed, coast/loss handling.
// Define TRACKER_STATS_EN to add saturating frame/miss statistics outputs.
module centroid_tracker #(
   parameter int unsigned COORD_W      = 11,
   parameter int unsigned ALPHA_SHIFT  = 2,
   parameter int unsigned JUMP_MAX     = 64,
   parameter int unsigned JUMP_CONFIRM = 3,
   parameter int unsigned LOST_FRAMES  = 8
) (
   input logic               iCLK,
   input logic               iRST,
   centroid_tracker_if.slave bus
`ifdef TRACKER_STATS_EN
   ,
   output logic [15:0]       oFrameCnt,
   output logic [15:0]       oMissCnt
`endif
);
   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, COAST = 2'd2} state_t;

   localparam int unsigned SW = COORD_W + 2;
   localparam int unsigned FW = $clog2(JUMP_CONFIRM + 1);
   localparam int unsigned MW = $clog2(LOST_FRAMES + 1);
   localparam logic [SW-1:0] JMAX = SW'(JUMP_MAX);

   state_t             state_q, state_d;
   logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
   logic [FW-1:0]      far_q, far_d, far_nx;
   logic [MW-1:0]      mcnt_q, mcnt_d, mcnt_nx;
   logic               got_q, req_q, ovr_q;
   logic               det, miss, upd, near;

   logic signed [SW-1:0] raw_r, raw_c, flt_r, flt_c, dr, dc, ema_r, ema_c;
   logic [SW-1:0]        abs_r, abs_c;

   function automatic logic [COORD_W-1:0] clamp(input logic signed [SW-1:0] v);
      if (v[SW-1])
         return '0;
      else if (v[SW-2:COORD_W] != '0)
         return '1;
      else
         return v[COORD_W-1:0];
   endfunction

   // Only the first iDVAL of a frame is taken; a frame closing without one is a miss.
   assign det  = bus.iDVAL & ~got_q;
   assign miss = bus.iFrameEnd & ~got_q & ~bus.iDVAL;

   assign raw_r = {2'b00, bus.iRow};
   assign raw_c = {2'b00, bus.iCol};
   assign flt_r = {2'b00, row_q};
   assign flt_c = {2'b00, col_q};
   assign dr    = raw_r - flt_r;
   assign dc    = raw_c - flt_c;
   assign abs_r = dr[SW-1] ? -dr : dr;
   assign abs_c = dc[SW-1] ? -dc : dc;
   assign near  = (abs_r <= JMAX) && (abs_c <= JMAX);
   assign ema_r = flt_r + (dr >>> ALPHA_SHIFT);
   assign ema_c = flt_c + (dc >>> ALPHA_SHIFT);
   assign far_nx  = far_q + 1'b1;
   assign mcnt_nx = mcnt_q + 1'b1;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)
         state_q <= SEARCH;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      far_d   = far_q;
      mcnt_d  = mcnt_q;
      upd     = 1'b0;
      case (state_q)
         SEARCH: begin
            if (det) begin
               row_d   = bus.iRow;
               col_d   = bus.iCol;
               far_d   = '0;
               mcnt_d  = '0;
               upd     = 1'b1;
               state_d = TRACK;
            end
         end
         TRACK, COAST: begin
            if (det) begin
               if (near) begin
                  row_d   = clamp(ema_r);
                  col_d   = clamp(ema_c);
                  far_d   = '0;
                  mcnt_d  = '0;
                  upd     = 1'b1;
                  state_d = TRACK;
               end else if (far_nx == FW'(JUMP_CONFIRM)) begin
                  row_d   = bus.iRow;
                  col_d   = bus.iCol;
                  far_d   = '0;
                  mcnt_d  = '0;
                  upd     = 1'b1;
                  state_d = TRACK;
               end else begin
                  far_d = far_nx;
               end
            end else if (miss) begin
               far_d = '0;
               if (state_q == TRACK) begin
                  mcnt_d  = MW'(1);
                  state_d = COAST;
               end else if (mcnt_nx == MW'(LOST_FRAMES)) begin
                  mcnt_d  = '0;
                  state_d = SEARCH;
               end else begin
                  mcnt_d = mcnt_nx;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_comb begin
      bus.oState   = state_q;
      bus.oValid   = (state_q != SEARCH);
      bus.oRow     = row_q;
      bus.oCol     = col_q;
      bus.oReq     = req_q;
      bus.oOverrun = ovr_q;
   end

   // An ack landing with a fresh update keeps oReq high but still clears overrun.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         row_q  <= '0;
         col_q  <= '0;
         far_q  <= '0;
         mcnt_q <= '0;
         got_q  <= 1'b0;
         req_q  <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         far_q  <= far_d;
         mcnt_q <= mcnt_d;
         if (bus.iFrameEnd)
            got_q <= 1'b0;
         else if (det)
            got_q <= 1'b1;
         if (req_q && bus.iAck)
            ovr_q <= 1'b0;
         else if (upd && req_q)
            ovr_q <= 1'b1;
         if (upd)
            req_q <= 1'b1;
         else if (bus.iAck)
            req_q <= 1'b0;
      end
   end

`ifdef TRACKER_STATS_EN
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oFrameCnt <= '0;
         oMissCnt  <= '0;
      end else begin
         if (bus.iFrameEnd && oFrameCnt != 16'hFFFF)
            oFrameCnt <= oFrameCnt + 16'd1;
         if (miss && oMissCnt != 16'hFFFF)
            oMissCnt <= oMissCnt + 16'd1;
      end
   end
`endif
endmodule
